uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- Oversampling UART receiver; sits directly upstream of the UART peripheral's RX FIFO.
- Converts the asynchronous serial line into one-cycle byte strobes (data_o / data_valid_o) suitable for direct connection to the FIFO write port.
- Reports framing and break errors, so the CPU-side peripheral can count them or expose them as status.

Parameters:
- FPGAClkSpeed, 1600000, system clock frequency in Hz.
- UARTBaudRate, 10000, line baud rate in Hz.
- OversampleRate, 16, oversample ticks per bit. Must be even and >= 4.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  reset; asynchronous assert, active-low (0 = reset).
- uart_rx_i  in  1  serial line, idle high, asynchronous to clk_i.
- data_o  out  8  last correctly framed byte, held until the next good byte.
- data_valid_o  out  1  one-cycle pulse when data_o updates.
- frame_error_o  out  1  one-cycle pulse when the stop bit samples 0.
- break_o  out  1  one-cycle pulse when a frame is all zeros and the stop bit is 0.
- parity_error_o  out  1  one-cycle pulse on parity mismatch; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset values: data_o=0x00, all pulse outputs 0, synchronizer flops 1, state IDLE, all counters 0.
- Synchronizer: uart_rx_i passes through 2 flops to give rx_s. This adds 2 clocks of latency.
- Divisor: DIV = FPGAClkSpeed / (UARTBaudRate*OversampleRate), integer floor. Elaboration fails if DIV < 1.
- Tick counter: runs 0..DIV-1 and raises a one-cycle tick at DIV-1. It is cleared on the IDLE->START transition so sampling is phase-aligned to the start edge.
- Sample counter: counts ticks 0..OversampleRate-1 within each bit. bit_cnt counts 0..7.
- States and transitions:
  - IDLE: when rx_s==0, go to START and clear both counters.
  - START: at sample count OversampleRate/2-1 (mid start bit):
    - if rx_s==1, treat it as a glitch and return to IDLE with no output;
    - otherwise clear the sample counter and go to DATA.
  - DATA: at each sample count OversampleRate-1 (mid-bit), shift rx_s into the shift register, LSB first. After bit 7, go to STOP (or PARITY when the optional feature is compiled in).
  - STOP: at the mid-bit sample:
    - rx_s==1: on the next clock, data_o = shift register and data_valid_o pulses for 1 cycle. Go to IDLE immediately, so a start bit arriving half a bit later is accepted.
    - rx_s==0: frame_error_o pulses for 1 cycle; break_o also pulses if the shift register is 0x00. data_o is unchanged and there is no valid pulse. Go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. A held break therefore produces exactly one error pulse.
- Latency: data_valid_o asserts 2 (synchronizer) + 1 (register) clocks after the mid-stop tick.
- Pulses are mutually exclusive except that frame_error_o and break_o assert together.
- Reset asserted mid-frame: state returns to IDLE and the partial byte is discarded. No pulse is emitted during reset or on release.
- Back-to-back frames with zero idle gap must be received without loss.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - adds a PARITY state between DATA and STOP that samples one bit at mid-bit;
  - even parity over the 8 data bits plus the parity bit;
  - on mismatch, parity_error_o pulses together with the STOP outcome and data_valid_o is suppressed;
  - the frame is 11 bits.
- Undefined:
  - PARITY state and its logic are absent;
  - parity_error_o is tied 0;
  - the frame is 8N1 (10 bits).

Decomposition:
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - a function uart_div(clk, baud, os) returning DIV;
  - the DATA_BITS=8 localparam.
- One sub-module, uart_baud_tick: the parameterised tick counter with a synchronous clear input and a tick output. It is reused later by the TX side.

Test Plan (defaults: DIV=10, 160 clocks/bit):
- Send 0xA5 as 8N1 -> exactly one data_valid_o pulse with data_o=0xA5, 1523±10 clocks after the start edge; frame_error_o stays 0.
- Low glitch of 40 clocks on an idle line -> no pulses, state returns to IDLE, and a following 0x3C is received correctly.
- 0x3C sent with stop bit 0 -> one frame_error_o pulse, no data_valid_o, data_o keeps its previous value.
- Line held low for 3000 clocks, then high -> exactly one frame_error_o and one break_o pulse, then a following 0x81 is received normally.
- 0x00, 0xFF, 0x55 sent back-to-back with no idle gap -> three data_valid_o pulses, in order, with the correct values.
- reset_i driven low during data bit 4, released, then 0x7E sent -> no pulse for the aborted frame, all outputs 0 during reset, 0x7E received. Under UART_RX_PARITY_EN, a wrong parity bit gives parity_error_o=1 and no data_valid_o.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the RX core and the baud tick generator.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StWaitHigh
   } rx_state_t;

   // Clock cycles per oversample tick, rounded down.
   function automatic int unsigned uart_div(input int unsigned clk, input int unsigned baud,
                                            input int unsigned os);
      return clk / (baud * os);
   endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Byte/status strobe bundle from the UART receiver towards the RX FIFO side.
interface uart_rx_core_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] data_o;
   logic                 data_valid_o;
   logic                 frame_error_o;
   logic                 break_o;
   logic                 parity_error_o;

   modport master (
      output data_o,
      output data_valid_o,
      output frame_error_o,
      output break_o,
      output parity_error_o
   );

   modport slave (
      input data_o,
      input data_valid_o,
      input frame_error_o,
      input break_o,
      input parity_error_o
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider with a synchronous phase-align clear.
module uart_baud_tick #(
   parameter int unsigned Div = 10
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      if (clr_i || (cnt_q == CntLast)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling 8N1 UART receiver with framing/break detection.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and parity_error_o.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned FPGAClkSpeed   = 1600000,
   parameter int unsigned UARTBaudRate   = 10000,
   parameter int unsigned OversampleRate = 16
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           uart_rx_i,
   uart_rx_core_if.master rx_if
);

   localparam int unsigned Div   = uart_div(FPGAClkSpeed, UARTBaudRate, OversampleRate);
   localparam int unsigned SampW = $clog2(OversampleRate);
   localparam int unsigned BitW  = $clog2(DATA_BITS);
   localparam logic [SampW-1:0] SampLast = SampW'(OversampleRate - 1);
   localparam logic [SampW-1:0] SampMid  = SampW'(OversampleRate / 2 - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

   if (Div < 1) begin : g_bad_div
      $error("uart_rx_core: clock too slow for baud rate and oversample rate");
   end
   if ((OversampleRate < 4) || (OversampleRate % 2 != 0)) begin : g_bad_os
      $error("uart_rx_core: OversampleRate must be even and >= 4");
   end

   logic                 rx_meta_q, rx_s_q;
   rx_state_t            state_q;
   logic [SampW-1:0]     samp_q;
   logic [BitW-1:0]      bit_q;
   logic [DATA_BITS-1:0] shift_q, data_q;
   logic                 valid_q, ferr_q, brk_q;
   logic                 tick, tick_clr, mid_bit;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Restart the tick phase on the start edge so samples land mid-bit.
   assign tick_clr = (state_q == StIdle) && !rx_s_q;
   assign mid_bit  = tick && (samp_q == SampLast);

   uart_baud_tick #(
      .Div(Div)
   ) u_baud_tick (
      .clk_i (clk_i),
      .rst_ni(reset_i),
      .clr_i (tick_clr),
      .tick_o(tick)
   );

`ifdef UART_RX_PARITY_EN
   logic par_q, perr_q, par_bad;
   assign par_bad = ^{shift_q, par_q};
`endif

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= StIdle;
         samp_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
         if (tick) begin
            samp_q <= (samp_q == SampLast) ? '0 : samp_q + 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               samp_q <= '0;
               bit_q  <= '0;
               if (!rx_s_q) state_q <= StStart;
            end
            StStart: begin
               if (tick && (samp_q == SampMid)) begin
                  samp_q  <= '0;
                  state_q <= rx_s_q ? StIdle : StData;
               end
            end
            StData: begin
               if (mid_bit) begin
                  shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= StParity;
`else
                     state_q <= StStop;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (mid_bit) begin
                  par_q   <= rx_s_q;
                  state_q <= StStop;
               end
            end
`endif
            StStop: begin
               if (mid_bit) begin
`ifdef UART_RX_PARITY_EN
                  perr_q <= par_bad;
`endif
                  if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
                     if (!par_bad) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                     end
`else
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
`endif
                     state_q <= StIdle;
                  end else begin
                     ferr_q  <= 1'b1;
                     brk_q   <= (shift_q == '0);
                     state_q <= StWaitHigh;
                  end
               end
            end
            StWaitHigh: begin
               if (rx_s_q) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rx_if.data_o        = data_q;
   assign rx_if.data_valid_o  = valid_q;
   assign rx_if.frame_error_o = ferr_q;
   assign rx_if.break_o       = brk_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.parity_error_o = perr_q;
`else
   assign rx_if.parity_error_o = 1'b0;
`endif

endmodule
